// File: rtl/sram_8t_array_ctrl.sv
// Sequencer for a word-organised 8T SRAM array: one request at a time, one-hot
// write/read wordline decode, bitline setup/pulse/hold and read-sense timing.
module sram_8t_array_ctrl #(
    parameter int ADDR_W     = 4,
    parameter int DATA_W     = 8,
    parameter int WPULSE_CYC = 2,
    parameter int RSENSE_CYC = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_we,
    input  logic [ADDR_W-1:0]        req_addr,
    input  logic [DATA_W-1:0]        req_wdata,
    output logic [(1<<ADDR_W)-1:0]   wwl,
    output logic [(1<<ADDR_W)-1:0]   rwl,
    output logic [DATA_W-1:0]        bl,
    input  logic [DATA_W-1:0]        array_q,
    output logic [DATA_W-1:0]        rdata,
    output logic                     rvalid,
    output logic                     wr_done
);

    localparam int ROWS    = 1 << ADDR_W;
    localparam int MAX_CYC = (WPULSE_CYC > RSENSE_CYC) ? WPULSE_CYC : RSENSE_CYC;
    localparam int CW      = $clog2(MAX_CYC) + 1;
    localparam logic [CW-1:0] WP_LAST = CW'(WPULSE_CYC - 1);
    localparam logic [CW-1:0] RS_LAST = CW'(RSENSE_CYC - 1);

    typedef enum logic [2:0] {
        IDLE,
        W_SETUP,
        W_PULSE,
        W_HOLD,
        R_SENSE,
        R_DONE
    } state_t;

    state_t              state_q;
    logic [CW-1:0]       cnt_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [ROWS-1:0]     wwl_q;
    logic [ROWS-1:0]     rwl_q;
    logic [DATA_W-1:0]   bl_q;
    logic [DATA_W-1:0]   rdata_q;
    logic                rvalid_q;
    logic                wr_done_q;
    logic                ready_q;

    function automatic logic [ROWS-1:0] oneHot(input logic [ADDR_W-1:0] a);
        logic [ROWS-1:0] v;
        v    = '0;
        v[a] = 1'b1;
        return v;
    endfunction

    // Every output is a register loaded on the transition into the state that
    // owns it, so nothing on the array side sees a request input combinationally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            wwl_q     <= '0;
            rwl_q     <= '0;
            bl_q      <= '0;
            rdata_q   <= '0;
            rvalid_q  <= 1'b0;
            wr_done_q <= 1'b0;
            ready_q   <= 1'b1;
        end else begin
            case (state_q)
                IDLE, R_DONE: begin
                    rvalid_q <= 1'b0;
                    if (req_valid) begin
                        addr_q  <= req_addr;
                        ready_q <= 1'b0;
                        if (req_we) begin
                            bl_q    <= req_wdata;
                            state_q <= W_SETUP;
                        end else begin
                            rwl_q   <= oneHot(req_addr);
                            cnt_q   <= RS_LAST;
                            state_q <= R_SENSE;
                        end
                    end else begin
                        state_q <= IDLE;
                    end
                end
                W_SETUP: begin
                    wwl_q   <= oneHot(addr_q);
                    cnt_q   <= WP_LAST;
                    state_q <= W_PULSE;
                end
                W_PULSE: begin
                    if (cnt_q == '0) begin
                        wwl_q     <= '0;
                        wr_done_q <= 1'b1;
                        state_q   <= W_HOLD;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                W_HOLD: begin
                    wr_done_q <= 1'b0;
                    bl_q      <= '0;
                    ready_q   <= 1'b1;
                    state_q   <= IDLE;
                end
                R_SENSE: begin
                    // Sample the column outputs while the read wordline is still high.
                    if (cnt_q == '0) begin
                        rwl_q    <= '0;
                        rdata_q  <= array_q;
                        rvalid_q <= 1'b1;
                        ready_q  <= 1'b1;
                        state_q  <= R_DONE;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign req_ready = ready_q & ~rst;
    assign wwl       = wwl_q;
    assign rwl       = rwl_q;
    assign bl        = bl_q;
    assign rdata     = rdata_q;
    assign rvalid    = rvalid_q;
    assign wr_done   = wr_done_q;

endmodule

// File: tb/tb_sram_8t_array_ctrl.sv
// Scoreboard bench for sram_8t_array_ctrl with a behavioural 8T array model,
// randomized traffic, reset aborts and a wordline-timing parameter sweep.
module tb_sram_8t_array_ctrl;

    localparam int AW   = 4;
    localparam int DW   = 8;
    localparam int ROWS = 16;
    localparam int WP   = 2;
    localparam int RS   = 1;

    logic            clk = 1'b0;
    logic            rst;
    logic            reqValid, reqWe, reqReady;
    logic [AW-1:0]   reqAddr;
    logic [DW-1:0]   reqWdata;
    logic [ROWS-1:0] wwl, rwl;
    logic [DW-1:0]   bl, arrayQ, rdata;
    logic            rvalid, wrDone;

    logic [1:0]      sValid, sWe, sReady, sRvalid, sWrDone;
    logic [AW-1:0]   sAddr;
    logic [DW-1:0]   sWdata, sQ;
    logic [ROWS-1:0] sWwl [2];
    logic [ROWS-1:0] sRwl [2];
    logic [DW-1:0]   sBl [2];
    logic [DW-1:0]   sRdata [2];

    always #5 clk = ~clk;

    sram_8t_array_ctrl #(.ADDR_W(AW), .DATA_W(DW), .WPULSE_CYC(WP), .RSENSE_CYC(RS)) dut (
        .clk(clk), .rst(rst), .req_valid(reqValid), .req_ready(reqReady), .req_we(reqWe),
        .req_addr(reqAddr), .req_wdata(reqWdata), .wwl(wwl), .rwl(rwl), .bl(bl),
        .array_q(arrayQ), .rdata(rdata), .rvalid(rvalid), .wr_done(wrDone));

    sram_8t_array_ctrl #(.ADDR_W(AW), .DATA_W(DW), .WPULSE_CYC(1), .RSENSE_CYC(3)) dutSweepA (
        .clk(clk), .rst(rst), .req_valid(sValid[0]), .req_ready(sReady[0]), .req_we(sWe[0]),
        .req_addr(sAddr), .req_wdata(sWdata), .wwl(sWwl[0]), .rwl(sRwl[0]), .bl(sBl[0]),
        .array_q(sQ), .rdata(sRdata[0]), .rvalid(sRvalid[0]), .wr_done(sWrDone[0]));

    sram_8t_array_ctrl #(.ADDR_W(AW), .DATA_W(DW), .WPULSE_CYC(4), .RSENSE_CYC(3)) dutSweepB (
        .clk(clk), .rst(rst), .req_valid(sValid[1]), .req_ready(sReady[1]), .req_we(sWe[1]),
        .req_addr(sAddr), .req_wdata(sWdata), .wwl(sWwl[1]), .rwl(sRwl[1]), .bl(sBl[1]),
        .array_q(sQ), .rdata(sRdata[1]), .rvalid(sRvalid[1]), .wr_done(sWrDone[1]));

    // Bitcell array: a row captures the bitlines on its write-wordline rising
    // edge; unselected rows drive 0 so the column outputs are a plain OR.
    logic [DW-1:0]   arrMem [ROWS];
    logic [ROWS-1:0] wwlPrev = '0;

    always @(wwl) begin
        for (int r = 0; r < ROWS; r++)
            if (wwl[r] === 1'b1 && wwlPrev[r] !== 1'b1) arrMem[r] = bl;
        wwlPrev = wwl;
    end

    always_comb begin
        arrayQ = '0;
        for (int r = 0; r < ROWS; r++)
            if (rwl[r]) arrayQ = arrayQ | arrMem[r];
    end

    typedef struct {
        bit            isWrite;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } exp_t;

    exp_t          expQ [$];
    logic [DW-1:0] refMem [ROWS];
    int nChecks = 0, nFails = 0, nIssued = 0, nHandshakes = 0, lastWait = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    always @(posedge clk)
        if (!rst && reqValid && reqReady) nHandshakes++;

    // Monitor: per-cycle wordline invariants plus in-order response checking.
    exp_t e;
    always @(negedge clk) begin
        if (!rst) begin
            checkOutput("onehot_wl", 32'($onehot0(wwl | rwl)), 32'd1);
            checkOutput("no_overlap", 32'(|(wwl & rwl)), 32'd0);
            if (rvalid || wrDone) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_resp", {30'd0, rvalid, wrDone}, 32'd0);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("resp_kind", {30'd0, rvalid, wrDone}, e.isWrite ? 32'd1 : 32'd2);
                    if (e.isWrite) checkOutput("array_cell", 32'(arrMem[e.addr]), 32'(e.data));
                    else           checkOutput("rdata", 32'(rdata), 32'(e.data));
                end
            end
        end
    end

    // Drives one request; while the controller is busy the fields are scrambled
    // so only the values present at the handshake may reach the array.
    task automatic applyStimulus(input bit we, input logic [AW-1:0] addr, input logic [DW-1:0] data);
        int guard = 0;
        @(negedge clk);
        while (!reqReady && guard < 40) begin
            reqValid = 1'b1;
            reqWe    = 1'($urandom);
            reqAddr  = AW'($urandom);
            reqWdata = DW'($urandom);
            guard++;
            @(negedge clk);
        end
        if (guard >= 40) checkOutput("ready_timeout", 32'(guard), 32'd0);
        lastWait = guard;
        reqValid = 1'b1;
        reqWe    = we;
        reqAddr  = addr;
        reqWdata = data;
        if (we) begin
            refMem[addr] = data;
            expQ.push_back('{1'b1, addr, data});
        end else begin
            expQ.push_back('{1'b0, addr, refMem[addr]});
        end
        nIssued++;
        @(posedge clk);
        #1;
        reqWe    = 1'($urandom);
        reqAddr  = AW'($urandom);
        reqWdata = DW'($urandom);
    endtask

    task automatic sweepOne(input int k, input int expOcc, input int expLat);
        int c;
        @(negedge clk);
        sAddr = 4'd6; sWdata = 8'h5A; sWe[k] = 1'b1; sValid[k] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        sValid[k] = 1'b0;
        c = 1;
        while (!sReady[k] && c < 20) begin @(negedge clk); c++; end
        checkOutput($sformatf("sweep%0d_wr_occupancy", k), 32'(c), 32'(expOcc));
        sQ = DW'($urandom); sWe[k] = 1'b0; sValid[k] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        sValid[k] = 1'b0;
        c = 1;
        while (!sRvalid[k] && c < 20) begin @(negedge clk); c++; end
        checkOutput($sformatf("sweep%0d_rd_latency", k), 32'(c), 32'(expLat));
        checkOutput($sformatf("sweep%0d_rdata", k), 32'(sRdata[k]), 32'(sQ));
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        rst = 1'b1; reqValid = 1'b0; reqWe = 1'b0; reqAddr = '0; reqWdata = '0;
        sValid = '0; sWe = '0; sAddr = '0; sWdata = '0; sQ = '0;
        for (int r = 0; r < ROWS; r++) begin arrMem[r] = '0; refMem[r] = '0; end
        repeat (2) @(negedge clk);
        checkOutput("reset_wwl", 32'(wwl), 32'd0);
        checkOutput("reset_rwl", 32'(rwl), 32'd0);
        checkOutput("reset_bl", 32'(bl), 32'd0);
        checkOutput("reset_rdata", 32'(rdata), 32'd0);
        checkOutput("reset_pulses", {30'd0, rvalid, wrDone}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("reset_ready", 32'(reqReady), 32'd1);

        // Directed write of 0xA5 to row 3 with cycle-exact checks.
        applyStimulus(1'b1, 4'd3, 8'hA5);
        for (int c = 1; c <= WP + 3; c++) begin
            @(negedge clk);
            if (c == 1) reqValid = 1'b0;
            checkOutput($sformatf("wr_bl_c%0d", c), 32'(bl), (c <= WP + 2) ? 32'hA5 : 32'd0);
            checkOutput($sformatf("wr_wwl_c%0d", c), 32'(wwl), (c >= 2 && c <= WP + 1) ? 32'h8 : 32'd0);
            checkOutput($sformatf("wr_done_c%0d", c), 32'(wrDone), (c == WP + 2) ? 32'd1 : 32'd0);
            checkOutput($sformatf("wr_ready_c%0d", c), 32'(reqReady), (c == WP + 3) ? 32'd1 : 32'd0);
        end

        // Directed read back of row 3.
        applyStimulus(1'b0, 4'd3, 8'h00);
        for (int c = 1; c <= RS + 1; c++) begin
            @(negedge clk);
            if (c == 1) reqValid = 1'b0;
            checkOutput($sformatf("rd_rwl_c%0d", c), 32'(rwl), (c <= RS) ? 32'h8 : 32'd0);
            checkOutput($sformatf("rd_rvalid_c%0d", c), 32'(rvalid), (c == RS + 1) ? 32'd1 : 32'd0);
            checkOutput($sformatf("rd_bl_c%0d", c), 32'(bl), 32'd0);
            if (c == RS + 1) checkOutput("rd_rdata_a5", 32'(rdata), 32'hA5);
        end

        // Back-to-back with valid held; the last read lands in the prior R_DONE.
        applyStimulus(1'b1, 4'd0, 8'h3C);
        applyStimulus(1'b1, 4'd15, 8'hC3);
        applyStimulus(1'b0, 4'd0, 8'h00);
        applyStimulus(1'b0, 4'd15, 8'h00);
        checkOutput("b2b_accept_in_rdone", 32'(lastWait), 32'(RS));

        // Busy-ignore: fields scramble while the write to row 5 is in flight.
        applyStimulus(1'b1, 4'd5, 8'h77);
        applyStimulus(1'b0, 4'd5, 8'h00);
        @(negedge clk); reqValid = 1'b0;
        repeat (3) @(negedge clk);

        // Reset in the second W_PULSE cycle: the row keeps the committed word.
        applyStimulus(1'b1, 4'd9, 8'h96);
        @(negedge clk); reqValid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("rstw_wwl_before", 32'(wwl), 32'h200);
        #2 rst = 1'b1; expQ.delete();
        #1;
        checkOutput("rstw_wwl", 32'(wwl), 32'd0);
        checkOutput("rstw_bl", 32'(bl), 32'd0);
        checkOutput("rstw_ready", 32'(reqReady), 32'd0);
        checkOutput("rstw_wr_done", 32'(wrDone), 32'd0);
        @(negedge clk); #2 rst = 1'b0;
        @(negedge clk);
        checkOutput("rstw_ready_after", 32'(reqReady), 32'd1);
        checkOutput("rstw_no_wr_done", 32'(wrDone), 32'd0);

        // Reset in R_SENSE aborts the read.
        applyStimulus(1'b0, 4'd9, 8'h00);
        @(negedge clk); reqValid = 1'b0;
        checkOutput("rstr_rwl_before", 32'(rwl), 32'h200);
        #2 rst = 1'b1; expQ.delete();
        #1;
        checkOutput("rstr_rwl", 32'(rwl), 32'd0);
        checkOutput("rstr_rdata", 32'(rdata), 32'd0);
        checkOutput("rstr_rvalid", 32'(rvalid), 32'd0);
        @(negedge clk); #2 rst = 1'b0;
        @(negedge clk);
        checkOutput("rstr_ready_after", 32'(reqReady), 32'd1);
        checkOutput("rstr_no_rvalid", 32'(rvalid), 32'd0);
        checkOutput("rstr_rdata_after", 32'(rdata), 32'd0);
        applyStimulus(1'b0, 4'd9, 8'h00);

        // Randomized traffic with occasional idle gaps.
        for (int n = 0; n < 60; n++) begin
            applyStimulus(1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom));
            if ($urandom_range(0, 3) == 0) begin
                @(negedge clk); reqValid = 1'b0;
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
        end
        @(negedge clk); reqValid = 1'b0;
        for (int g = 0; g < 50 && expQ.size() > 0; g++) @(negedge clk);
        checkOutput("drain_queue", 32'(expQ.size()), 32'd0);
        checkOutput("handshake_count", 32'(nHandshakes), 32'(nIssued));

        sweepOne(0, 4, 4);
        sweepOne(1, 7, 4);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/sram_8t_array_ctrl.md
# sram_8t_array_ctrl

Sequencing controller for a word-organised array of 8T SRAM bitcells (write wordline, read wordline, shared bitline per column, gated read output). It accepts one read or write request at a time over a valid/ready handshake, decodes the address to one-hot write/read wordlines, and times bitline setup, write pulse, bitline hold and read sensing. It sits between a digital requester and the bitcell array; column read outputs arrive already OR-combined on `array_q`, because unselected cells drive 0.

## Interface
- `ADDR_W`, 4: address width; the array has 2^ADDR_W rows.
- `DATA_W`, 8: word width, one bitcell column per bit.
- `WPULSE_CYC`, 2: write wordline high time in clocks, ≥1.
- `RSENSE_CYC`, 1: read wordline high time in clocks, ≥1.

Ports:
- `clk` in 1: single clock, all state on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: controller idle and accepting.
- `req_we` in 1: 1 = write, 0 = read.
- `req_addr` in ADDR_W: row address.
- `req_wdata` in DATA_W: write word.
- `wwl` out 2^ADDR_W: one-hot write wordlines to array rows.
- `rwl` out 2^ADDR_W: one-hot read wordlines to array rows.
- `bl` out DATA_W: bitline drive to array columns.
- `array_q` in DATA_W: combined column read outputs.
- `rdata` out DATA_W: captured read word.
- `rvalid` out 1: one-cycle pulse, `rdata` valid.
- `wr_done` out 1: one-cycle pulse, write sequence finished.

## Operation
- FSM states: IDLE, W_SETUP, W_PULSE, W_HOLD, R_SENSE, R_DONE. Cycle counter of width clog2(max(WPULSE_CYC,RSENSE_CYC))+1.
- IDLE: `req_ready`=1. On `req_valid && req_ready`, latch addr/we/wdata; go to W_SETUP if we=1, else R_SENSE. Request inputs are ignored in all other states.
- W_SETUP (1 cycle): `bl`=latched wdata, all `wwl`=0. Go to W_PULSE.
- W_PULSE (WPULSE_CYC cycles): `wwl[addr]`=1, others 0, `bl` held. The cell commits on the wwl rising edge. Go to W_HOLD.
- W_HOLD (1 cycle): `wwl`=0, `bl` still held, `wr_done`=1. Go to IDLE.
- R_SENSE (RSENSE_CYC cycles): `rwl[addr]`=1, others 0. On the clock edge that ends the last cycle, `rdata` <= `array_q`. Go to R_DONE.
- R_DONE (1 cycle): `rwl`=0, `rvalid`=1, `req_ready`=1. A handshake here is accepted exactly as in IDLE, giving back-to-back requests.
- `bl` = 0 in all states except W_SETUP/W_PULSE/W_HOLD. `rdata` holds its value until the next read capture.
- Invariants: at most one bit of `wwl|rwl` high; `wwl` and `rwl` are never high in the same cycle.
- Outputs `wwl`, `rwl`, `bl`, `req_ready`, `rvalid` and `wr_done` decode from registered state and latched fields only, with no combinational path from request inputs.

## Timing
- Reset (async, immediate): state=IDLE, `wwl`=0, `rwl`=0, `bl`=0, `rdata`=0, `rvalid`=0, `wr_done`=0, `req_ready`=1 once deasserted.
- Reset during W_PULSE drops `wwl` at once. The row keeps the value committed at the pulse edge, and no `wr_done` is issued.
- Reset during R_SENSE aborts the read: no `rvalid`, and `rdata` reads 0.
- Write, handshake at edge 0:
  - W_SETUP in cycle 1.
  - `wwl` high in cycles 2..WPULSE_CYC+1.
  - W_HOLD/`wr_done` in cycle WPULSE_CYC+2.
  - Next accept at cycle WPULSE_CYC+3.
  - Total occupancy is WPULSE_CYC+3 cycles including the accept cycle.
- Read, handshake at edge 0:
  - `rwl` high in cycles 1..RSENSE_CYC.
  - `rvalid`/`rdata` valid in cycle RSENSE_CYC+1, when the next request may also be accepted.
- `req_valid` may be held through busy cycles. Exactly one handshake occurs per request, and the fields are sampled only at that handshake.

## Test plan
- Write addr 3, data 0xA5 (defaults): `bl`=0xA5 from cycle 1 to cycle 4; `wwl`=16'h0008 in cycles 2–3 only; `wr_done` in cycle 4; `req_ready` low cycles 1–4.
- Read addr 3 after that write, with a behavioural 16×8 array model: `rwl`=16'h0008 in cycle 1; `rvalid` in cycle 2 with `rdata`=0xA5; `bl`=0 throughout.
- Back-to-back: writes 0x3C@0 and 0xC3@15, then reads @0 and @15 with `req_valid` held high. Reads return 0x3C then 0xC3; the second read is accepted in the R_DONE cycle of the first; one-hot and no-overlap assertions hold every cycle.
- Busy-ignore: a write to addr 5 is in flight; change `req_addr`/`req_wdata` every cycle while busy. Only the values at the handshake reach the array; no extra handshakes occur.
- Reset in W_PULSE cycle 2, then in R_SENSE: all outputs 0 asynchronously; no `wr_done`/`rvalid`; `req_ready`=1 in the first cycle after deassert.
- Parameter sweep WPULSE_CYC=1,4 and RSENSE_CYC=3: write occupancy 4 and 7 cycles; `rvalid` in cycle 4 after the read handshake.
